id_ex_ctrl: RTL and testbench
=============================

Name: id_ex_ctrl

Overview:
- Decode-stage controller for the RV32I pipeline.
- Classifies the ID-stage instruction and drives the immediate-type select of the immediate extender.
- Detects load-use hazards and sequences the ID/EX pipeline register: advance, bubble, freeze or flush.
- Exports a saturating bubble counter for performance monitoring.

Parameters:
CNT_W, 16, width of the load-use bubble counter (saturating)

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
id_inst  input  32  instruction in the ID stage
id_valid  input  1  id_inst is a real instruction (0 = bubble)
mem_stall  input  1  downstream memory not ready; freeze ID and EX
br_flush  input  1  EX resolved a taken branch or jump; kill IF/ID and ID/EX contents
id_imm_type  output  3  combinational immediate-type select for the immediate extender (Parameters.v encodings)
stall_if_id  output  1  hold PC and the IF/ID register this cycle
flush_if_id  output  1  invalidate the IF/ID register at the next edge
ex_valid  output  1  registered: EX holds a real instruction
ex_imm_type  output  3  registered id_imm_type
ex_mem_read  output  1  registered: EX instruction is a load
ex_rd  output  5  registered rd (forced 0 for S/B types)
ex_rs1  output  5  registered rs1
ex_rs2  output  5  registered rs2
bubble_cnt  output  CNT_W  count of load-use bubbles inserted since reset

Behaviour:
- Immediate-type encodings (Parameters.v): RTYPE=0, ITYPE=1, STYPE=2, BTYPE=3, UTYPE=4, JTYPE=5.
- Decode of opcode id_inst[6:0] to id_imm_type (purely combinational, 0 latency):
  - 0110111 (LUI) and 0010111 (AUIPC) -> UTYPE
  - 1101111 (JAL) -> JTYPE
  - 1100111 (JALR), 0000011 (LOAD), 0010011 (OP-IMM) -> ITYPE
  - 0100011 (STORE) -> STYPE
  - 1100011 (BRANCH) -> BTYPE
  - 0110011 (OP) and any other opcode -> RTYPE
- Source usage:
  - uses_rs1: R, I, S and B types.
  - uses_rs2: R, S and B types.
  - U and J types use no source register.
  - Unknown opcodes, decoded as RTYPE, are treated as using both sources (conservative).
- Load-use hazard (lu_haz) is true when all of the following hold:
  - ex_valid=1, ex_mem_read=1, ex_rd!=0, id_valid=1
  - and either (uses_rs1 and id_inst[19:15]==ex_rd) or (uses_rs2 and id_inst[24:20]==ex_rd).
- Priority per cycle (highest first):
  1. mem_stall=1:
     - stall_if_id=1, flush_if_id=0.
     - All ex_* registers hold; bubble_cnt holds.
     - br_flush is ignored; EX re-asserts it after the stall.
  2. br_flush=1:
     - flush_if_id=1, stall_if_id=0.
     - Next edge: ex_valid<=0, ex_mem_read<=0, ex_rd<=0, other ex_* don't-care (they load as usual).
     - No bubble counted, even if lu_haz is also true.
  3. lu_haz=1:
     - stall_if_id=1, flush_if_id=0.
     - Next edge: ex_valid<=0, ex_mem_read<=0, ex_rd<=0.
     - bubble_cnt increments unless it is already all-ones (saturates).
     - Exactly one bubble per hazard: the following cycle ex_valid=0, so lu_haz drops and ID advances.
  4. Otherwise (advance):
     - stall_if_id=0, flush_if_id=0.
     - Next edge: ex_valid<=id_valid.
     - ex_imm_type<=id_imm_type; ex_rs1<=id_inst[19:15]; ex_rs2<=id_inst[24:20].
     - ex_rd<=id_inst[11:7], or 0 when type is S/B or id_valid=0.
     - ex_mem_read<=(opcode==0000011) & id_valid.
- Latency: ID to EX is 1 cycle; stall and flush outputs are combinational in the same cycle as their cause.
- stall_if_id and flush_if_id are never both 1.
- Reset (asynchronous, any time including mid-stall):
  - ex_valid=0, ex_imm_type=0, ex_mem_read=0, ex_rd=0, ex_rs1=0, ex_rs2=0, bubble_cnt=0.
  - Combinational outputs follow their inputs during reset.
  - stall_if_id and flush_if_id are forced 0 while rst=1.
- x0 as destination never causes a hazard. A load to x0 still sets ex_mem_read=1.

Test Plan:
- Decode sweep: drive each of the 9 listed opcodes plus 1111111 with id_valid=1 -> id_imm_type = U,U,J,I,I,I,S,B,R,R; the next cycle ex_imm_type matches.
- Load-use: EX holds lw x5 (ex_mem_read=1, ex_rd=5), ID holds add x6,x5,x7 -> stall_if_id=1; next cycle ex_valid=0 and bubble_cnt=1; the following cycle the add enters EX with ex_rs1=5.
- No false hazard:
  - lw x0 followed by add x1,x0,x0 -> no stall.
  - lw x5 followed by lui x5 -> no stall.
  - lw x5 followed by addi x1,x2,5 -> no stall (rs2 field ignored for I type).
- Priority: lu_haz and br_flush in the same cycle -> flush_if_id=1, stall_if_id=0, bubble_cnt unchanged; add mem_stall=1 -> only stall_if_id=1 and ex_* unchanged.
- Saturation: with CNT_W=2, force 5 load-use hazards -> bubble_cnt sequence 1,2,3,3,3.
- Reset mid-operation: assert rst asynchronously during a load-use stall -> ex_valid, ex_rd and bubble_cnt go 0 immediately, without waiting for a clock edge; after release the first valid ID instruction advances normally.

Source files
------------

// File: rtl/id_ex_ctrl.sv
// RV32I decode-stage controller: immediate-type decode, load-use hazard detection
// and ID/EX register sequencing (advance / bubble / freeze / flush).
module id_ex_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      id_inst,
   input  logic             id_valid,
   input  logic             mem_stall,
   input  logic             br_flush,
   output logic [2:0]       id_imm_type,
   output logic             stall_if_id,
   output logic             flush_if_id,
   output logic             ex_valid,
   output logic [2:0]       ex_imm_type,
   output logic             ex_mem_read,
   output logic [4:0]       ex_rd,
   output logic [4:0]       ex_rs1,
   output logic [4:0]       ex_rs2,
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam logic [2:0] RTYPE = 3'd0;
   localparam logic [2:0] ITYPE = 3'd1;
   localparam logic [2:0] STYPE = 3'd2;
   localparam logic [2:0] BTYPE = 3'd3;
   localparam logic [2:0] UTYPE = 3'd4;
   localparam logic [2:0] JTYPE = 3'd5;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   logic [6:0]       w_opcode;
   logic [4:0]       w_rd;
   logic [4:0]       w_rs1;
   logic [4:0]       w_rs2;
   logic [2:0]       w_imm_type;
   logic             w_uses_rs1;
   logic             w_uses_rs2;
   logic             w_lu_haz;
   logic             w_no_rd;
   logic             w_unused_bits;

   logic             r_ex_valid;
   logic [2:0]       r_ex_imm_type;
   logic             r_ex_mem_read;
   logic [4:0]       r_ex_rd;
   logic [4:0]       r_ex_rs1;
   logic [4:0]       r_ex_rs2;
   logic [CNT_W-1:0] r_bubble_cnt;

   assign w_opcode      = id_inst[6:0];
   assign w_rd          = id_inst[11:7];
   assign w_rs1         = id_inst[19:15];
   assign w_rs2         = id_inst[24:20];
   assign w_unused_bits = ^{id_inst[31:25], id_inst[14:12]};

   always_comb begin
      w_imm_type = RTYPE;
      case (w_opcode)
         OP_LUI, OP_AUIPC:            w_imm_type = UTYPE;
         OP_JAL:                      w_imm_type = JTYPE;
         OP_JALR, OP_LOAD, OP_OPIMM:  w_imm_type = ITYPE;
         OP_STORE:                    w_imm_type = STYPE;
         OP_BRANCH:                   w_imm_type = BTYPE;
         default:                     w_imm_type = RTYPE;
      endcase
   end

   // Unknown opcodes fall into RTYPE, so they conservatively claim both sources.
   assign w_uses_rs1 = (w_imm_type == RTYPE) || (w_imm_type == ITYPE) ||
                       (w_imm_type == STYPE) || (w_imm_type == BTYPE);
   assign w_uses_rs2 = (w_imm_type == RTYPE) || (w_imm_type == STYPE) ||
                       (w_imm_type == BTYPE);

   assign w_lu_haz = r_ex_valid && r_ex_mem_read && (r_ex_rd != 5'd0) && id_valid &&
                     ((w_uses_rs1 && (w_rs1 == r_ex_rd)) ||
                      (w_uses_rs2 && (w_rs2 == r_ex_rd)));

   assign w_no_rd = (w_imm_type == STYPE) || (w_imm_type == BTYPE) || !id_valid;

   assign id_imm_type = w_imm_type;
   assign stall_if_id = !rst && (mem_stall || (!br_flush && w_lu_haz));
   assign flush_if_id = !rst && !mem_stall && br_flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ex_valid    <= 1'b0;
         r_ex_imm_type <= RTYPE;
         r_ex_mem_read <= 1'b0;
         r_ex_rd       <= 5'd0;
         r_ex_rs1      <= 5'd0;
         r_ex_rs2      <= 5'd0;
         r_bubble_cnt  <= '0;
      end else if (!mem_stall) begin
         r_ex_imm_type <= w_imm_type;
         r_ex_rs1      <= w_rs1;
         r_ex_rs2      <= w_rs2;
         if (br_flush || w_lu_haz) begin
            r_ex_valid    <= 1'b0;
            r_ex_mem_read <= 1'b0;
            r_ex_rd       <= 5'd0;
            // A flush kills the hazard victim anyway, so only real bubbles count.
            if (!br_flush && (r_bubble_cnt != {CNT_W{1'b1}}))
               r_bubble_cnt <= r_bubble_cnt + 1'b1;
         end else begin
            r_ex_valid    <= id_valid;
            r_ex_mem_read <= (w_opcode == OP_LOAD) && id_valid;
            r_ex_rd       <= w_no_rd ? 5'd0 : w_rd;
         end
      end
   end

   assign ex_valid    = r_ex_valid;
   assign ex_imm_type = r_ex_imm_type;
   assign ex_mem_read = r_ex_mem_read;
   assign ex_rd       = r_ex_rd;
   assign ex_rs1      = r_ex_rs1;
   assign ex_rs2      = r_ex_rs2;
   assign bubble_cnt  = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_ctrl.sv
// Scoreboard bench for id_ex_ctrl: the driver pushes hand-computed expectations,
// a monitor pops and compares combinational and registered outputs each cycle.
module tb_id_ex_ctrl;

   localparam int TB_CNT_W = 2;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_BAD    = 7'b1111111;

   logic                clk;
   logic                rst;
   logic [31:0]         id_inst;
   logic                id_valid;
   logic                mem_stall;
   logic                br_flush;
   logic [2:0]          id_imm_type;
   logic                stall_if_id;
   logic                flush_if_id;
   logic                ex_valid;
   logic [2:0]          ex_imm_type;
   logic                ex_mem_read;
   logic [4:0]          ex_rd;
   logic [4:0]          ex_rs1;
   logic [4:0]          ex_rs2;
   logic [TB_CNT_W-1:0] bubble_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [2:0] imm;
      logic       st;
      logic       fl;
   } comb_t;

   typedef struct {
      logic       v;
      logic [2:0] imm;
      logic       mr;
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [1:0] cnt;
      logic       ops;
   } reg_t;

   comb_t q_comb[$];
   reg_t  q_reg[$];

   id_ex_ctrl #(.CNT_W(TB_CNT_W)) dut (
      .clk(clk), .rst(rst), .id_inst(id_inst), .id_valid(id_valid),
      .mem_stall(mem_stall), .br_flush(br_flush), .id_imm_type(id_imm_type),
      .stall_if_id(stall_if_id), .flush_if_id(flush_if_id), .ex_valid(ex_valid),
      .ex_imm_type(ex_imm_type), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .bubble_cnt(bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b000, rd, op};
   endfunction

   // Drive one cycle of stimulus at the falling edge and queue its expectations.
   task automatic vec(input logic [31:0] inst, input logic v, input logic ms, input logic bf,
                      input logic [2:0] e_imm, input logic e_st, input logic e_fl,
                      input logic e_v, input logic [2:0] e_eimm, input logic e_mr,
                      input logic [4:0] e_rd, input logic [4:0] e_rs1, input logic [4:0] e_rs2,
                      input logic [1:0] e_cnt, input logic e_ops);
      comb_t c;
      reg_t  r;
      @(negedge clk);
      id_inst   = inst;
      id_valid  = v;
      mem_stall = ms;
      br_flush  = bf;
      c.imm = e_imm; c.st = e_st; c.fl = e_fl;
      r.v = e_v; r.imm = e_eimm; r.mr = e_mr; r.rd = e_rd;
      r.rs1 = e_rs1; r.rs2 = e_rs2; r.cnt = e_cnt; r.ops = e_ops;
      q_comb.push_back(c);
      q_reg.push_back(r);
   endtask

   initial begin : monitor
      comb_t c;
      reg_t  r;
      forever begin
         @(negedge clk);
         #4;
         if (q_comb.size() > 0) begin
            c = q_comb.pop_front();
            chk("id_imm_type", 32'(id_imm_type), 32'(c.imm));
            chk("stall_if_id", 32'(stall_if_id), 32'(c.st));
            chk("flush_if_id", 32'(flush_if_id), 32'(c.fl));
         end
         @(posedge clk);
         #1;
         if (q_reg.size() > 0) begin
            r = q_reg.pop_front();
            chk("ex_valid", 32'(ex_valid), 32'(r.v));
            chk("ex_mem_read", 32'(ex_mem_read), 32'(r.mr));
            chk("ex_rd", 32'(ex_rd), 32'(r.rd));
            chk("bubble_cnt", 32'(bubble_cnt), 32'(r.cnt));
            if (r.ops) begin
               chk("ex_imm_type", 32'(ex_imm_type), 32'(r.imm));
               chk("ex_rs1", 32'(ex_rs1), 32'(r.rs1));
               chk("ex_rs2", 32'(ex_rs2), 32'(r.rs2));
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: got timeout expected end of stimulus");
      $fatal(1, "bench timeout");
   end

   logic [6:0] sw_op  [10] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD,
                               OP_OPIMM, OP_STORE, OP_BRANCH, OP_OP, OP_BAD};
   logic [2:0] sw_imm [10] = '{3'd4, 3'd4, 3'd5, 3'd1, 3'd1, 3'd1, 3'd2, 3'd3, 3'd0, 3'd0};
   logic       sw_mr  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   logic [4:0] sw_rd  [10] = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd0, 5'd0, 5'd1, 5'd1};
   logic [1:0] sat_exp [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

   initial begin : driver
      logic [31:0] lw5, add657;
      logic [1:0]  prev;
      lw5    = enc(OP_LOAD, 5'd5, 5'd2, 5'd0);
      add657 = enc(OP_OP, 5'd6, 5'd5, 5'd7);

      // Reset state; stall is masked even with mem_stall high.
      rst = 1'b1; id_inst = enc(OP_LUI, 5'd3, 5'd0, 5'd0); id_valid = 1'b1;
      mem_stall = 1'b1; br_flush = 1'b1;
      #3;
      chk("rst ex_valid", 32'(ex_valid), 32'd0);
      chk("rst ex_rd", 32'(ex_rd), 32'd0);
      chk("rst bubble_cnt", 32'(bubble_cnt), 32'd0);
      chk("rst ex_rs1", 32'(ex_rs1), 32'd0);
      chk("rst stall", 32'(stall_if_id), 32'd0);
      chk("rst flush", 32'(flush_if_id), 32'd0);
      chk("rst id_imm_type", 32'(id_imm_type), 32'd4);
      @(negedge clk);
      rst = 1'b0; id_valid = 1'b0; mem_stall = 1'b0; br_flush = 1'b0;

      // Decode sweep
      for (int i = 0; i < 10; i++)
         vec(enc(sw_op[i], 5'd1, 5'd2, 5'd3), 1'b1, 1'b0, 1'b0, sw_imm[i], 1'b0, 1'b0,
             1'b1, sw_imm[i], sw_mr[i], sw_rd[i], 5'd2, 5'd3, 2'd0, 1'b1);

      // Invalid load: no mem_read, rd forced 0
      vec(enc(OP_LOAD, 5'd9, 5'd4, 5'd8), 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0,
          1'b0, 3'd1, 1'b0, 5'd0, 5'd4, 5'd8, 2'd0, 1'b1);

      // Load-use: one bubble, then the add advances
      vec(lw5, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 5'd5, 5'd2, 5'd0, 2'd0, 1'b1);
      vec(add657, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd1, 1'b0);
      vec(add657, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 5'd6, 5'd5, 5'd7, 2'd1, 1'b1);

      // No false hazards
      vec(enc(OP_LOAD, 5'd0, 5'd2, 5'd0), 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0,
          1'b1, 3'd1, 1'b1, 5'd0, 5'd2, 5'd0, 2'd1, 1'b1);
      vec(enc(OP_OP, 5'd1, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0,
          1'b1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 2'd1, 1'b1);
      vec(lw5, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 5'd5, 5'd2, 5'd0, 2'd1, 1'b1);
      vec(enc(OP_LUI, 5'd5, 5'd5, 5'd5), 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0,
          1'b1, 3'd4, 1'b0, 5'd5, 5'd5, 5'd5, 2'd1, 1'b1);
      vec(lw5, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 5'd5, 5'd2, 5'd0, 2'd1, 1'b1);
      vec(enc(OP_OPIMM, 5'd1, 5'd2, 5'd5), 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0,
          1'b1, 3'd1, 1'b0, 5'd1, 5'd2, 5'd5, 2'd1, 1'b1);

      // Priority: flush beats hazard, mem_stall beats both
      vec(lw5, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 5'd5, 5'd2, 5'd0, 2'd1, 1'b1);
      vec(add657, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd1, 1'b0);
      vec(lw5, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 5'd5, 5'd2, 5'd0, 2'd1, 1'b1);
      vec(add657, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 5'd5, 5'd2, 5'd0, 2'd1, 1'b1);
      vec(add657, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 2'd2, 1'b0);
      vec(add657, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 5'd6, 5'd5, 5'd7, 2'd2, 1'b1);

      // Asynchronous reset in the middle of a load-use stall
      vec(lw5, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 5'd5, 5'd2, 5'd0, 2'd2, 1'b1);
      @(negedge clk);
      id_inst = add657; id_valid = 1'b1; mem_stall = 1'b0; br_flush = 1'b0;
      #1;
      chk("pre-rst stall", 32'(stall_if_id), 32'd1);
      chk("pre-rst bubble_cnt", 32'(bubble_cnt), 32'd2);
      #1;
      rst = 1'b1;
      #1;
      chk("async ex_valid", 32'(ex_valid), 32'd0);
      chk("async ex_rd", 32'(ex_rd), 32'd0);
      chk("async bubble_cnt", 32'(bubble_cnt), 32'd0);
      chk("async stall", 32'(stall_if_id), 32'd0);
      @(negedge clk);
      rst = 1'b0; id_valid = 1'b0;
      vec(add657, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 5'd6, 5'd5, 5'd7, 2'd0, 1'b1);

      // Counter saturation with a 2-bit counter
      for (int i = 0; i < 5; i++) begin
         prev = (i == 0) ? 2'd0 : sat_exp[i-1];
         vec(lw5, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1, 5'd5, 5'd2, 5'd0, prev, 1'b1);
         vec(add657, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0,
             sat_exp[i], 1'b0);
         vec(add657, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 5'd6, 5'd5, 5'd7,
             sat_exp[i], 1'b1);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard drained", 32'(q_comb.size() + q_reg.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
